// File: rtl/i2c_reg_seq_if.sv
// Bundle between the register sequencer, its external register table and the i2c_com write engine.
interface i2c_reg_seq_if;
  logic [31:0] i2c_data;
  logic        start;
  logic        fl_read;
  logic        tr_end;
  logic [7:0]  lut_index;
  logic [23:0] lut_data;

  modport master (
    output i2c_data, start, fl_read, lut_index,
    input  tr_end, lut_data
  );

  modport slave (
    input  i2c_data, start, fl_read, lut_index,
    output tr_end, lut_data
  );
endinterface

// File: rtl/i2c_reg_seq.sv
// OV5640 register-table sequencer: waits out power-up, then issues one i2c_com write frame per table entry.
// Define I2C_SEQ_DELAY_CMD_EN to treat reg_addr 16'hFFFF entries as delay pseudo-commands.
module i2c_reg_seq #(
  parameter logic [7:0]  DEV_ADDR    = 8'h78,
  parameter logic [7:0]  LUT_SIZE    = 8'd252,
  parameter logic [19:0] PWRUP_CYC   = 20'd20000,
  parameter logic [7:0]  GAP_CYC     = 8'd4,
  parameter logic [15:0] MS_CYC      = 16'd40,
  parameter logic [7:0]  TIMEOUT_CYC = 8'd80
) (
  input  logic          clock_i2c2,
  input  logic          camera_rstn,
  input  logic          cfg_restart,
  i2c_reg_seq_if.master i2c,
  output logic          busy,
  output logic          cfg_done,
  output logic          cfg_err
);

  localparam logic [2:0] S_PWRUP     = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_KICK      = 3'd2;
  localparam logic [2:0] S_WAIT      = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;
  localparam logic [2:0] S_IDLE_DONE = 3'd5;
`ifdef I2C_SEQ_DELAY_CMD_EN
  localparam logic [2:0] S_DELAY     = 3'd6;
  localparam int         CNT_W       = 24;
`else
  localparam int         CNT_W       = 20;
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]       lut_index_q, lut_index_d;
  logic [31:0]      i2c_data_q, i2c_data_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             restart_pend_q, restart_pend_d;
  logic             restart_req, apply_restart;

`ifdef I2C_SEQ_DELAY_CMD_EN
  // The delay entry's index is already advanced on leaving DELAY, so the following GAP must not bump it again.
  logic             from_delay_q, from_delay_d;
  logic [23:0]      delay_cyc;
  assign delay_cyc = {16'd0, i2c_data_q[7:0]} * {8'd0, MS_CYC};
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lut_index_d    = lut_index_q;
    i2c_data_d     = i2c_data_q;
    cfg_done_d     = cfg_done_q;
    cfg_err_d      = cfg_err_q;
    restart_pend_d = restart_pend_q | cfg_restart;
    restart_req    = restart_pend_q | cfg_restart;
    apply_restart  = 1'b0;
    cnt_inc        = cnt_q + CNT_W'(1);
`ifdef I2C_SEQ_DELAY_CMD_EN
    from_delay_d   = from_delay_q;
`endif
    case (state_q)
      S_PWRUP: begin
        if (restart_req) begin
          apply_restart = 1'b1;
        end else if (cnt_inc >= CNT_W'(PWRUP_CYC)) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_LOAD: begin
        if (restart_req) begin
          apply_restart = 1'b1;
        end else if (lut_index_q == LUT_SIZE) begin
          state_d    = S_IDLE_DONE;
          cfg_done_d = 1'b1;
        end else begin
          i2c_data_d = {DEV_ADDR, i2c.lut_data};
          cnt_d      = '0;
`ifdef I2C_SEQ_DELAY_CMD_EN
          from_delay_d = 1'b0;
          if (i2c.lut_data[23:8] == 16'hFFFF) state_d = S_DELAY;
          else
`endif
          state_d = S_KICK;
        end
      end
      S_KICK: begin
        if (cnt_q[0]) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT: begin
        if (i2c.tr_end) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else if (cnt_inc >= CNT_W'(TIMEOUT_CYC)) begin
          state_d   = S_GAP;
          cnt_d     = '0;
          cfg_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAP: begin
        if (cnt_inc >= CNT_W'(GAP_CYC)) begin
          cnt_d = '0;
          if (restart_req) begin
            apply_restart = 1'b1;
          end else begin
            state_d = S_LOAD;
`ifdef I2C_SEQ_DELAY_CMD_EN
            if (!from_delay_q)
`endif
            lut_index_d = lut_index_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
`ifdef I2C_SEQ_DELAY_CMD_EN
      S_DELAY: begin
        if (cnt_inc >= delay_cyc) begin
          state_d      = S_GAP;
          cnt_d        = '0;
          lut_index_d  = lut_index_q + 8'd1;
          from_delay_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`endif
      S_IDLE_DONE: begin
        if (restart_req) apply_restart = 1'b1;
      end
      default: state_d = S_PWRUP;
    endcase

    // A restart skips power-up and reruns the table from entry 0.
    if (apply_restart) begin
      state_d        = S_LOAD;
      cnt_d          = '0;
      lut_index_d    = 8'd0;
      cfg_done_d     = 1'b0;
      cfg_err_d      = 1'b0;
      restart_pend_d = 1'b0;
    end

    start_d = (state_d != S_KICK);
    busy_d  = (state_d != S_IDLE_DONE);
  end

  always_ff @(posedge clock_i2c2 or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state_q        <= S_PWRUP;
      cnt_q          <= '0;
      lut_index_q    <= 8'd0;
      i2c_data_q     <= 32'd0;
      start_q        <= 1'b1;
      busy_q         <= 1'b1;
      cfg_done_q     <= 1'b0;
      cfg_err_q      <= 1'b0;
      restart_pend_q <= 1'b0;
`ifdef I2C_SEQ_DELAY_CMD_EN
      from_delay_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lut_index_q    <= lut_index_d;
      i2c_data_q     <= i2c_data_d;
      start_q        <= start_d;
      busy_q         <= busy_d;
      cfg_done_q     <= cfg_done_d;
      cfg_err_q      <= cfg_err_d;
      restart_pend_q <= restart_pend_d;
`ifdef I2C_SEQ_DELAY_CMD_EN
      from_delay_q   <= from_delay_d;
`endif
    end
  end

  assign i2c.i2c_data  = i2c_data_q;
  assign i2c.start     = start_q;
  assign i2c.fl_read   = 1'b0;
  assign i2c.lut_index = lut_index_q;
  assign busy          = busy_q;
  assign cfg_done      = cfg_done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq: a small i2c_com model answers each frame, a queue scoreboards the frame words.
// Covers sweep, timeout, restart, delay entry (I2C_SEQ_DELAY_CMD_EN), async reset and an empty table.
module tb_i2c_reg_seq;
  localparam int PWRUP = 10;
  localparam int TMO   = 80;
  localparam logic [23:0] E0 = 24'h310311, E1 = 24'h300882, E2 = 24'h300842, EDLY = 24'hFFFF05;

  logic clock_i2c2 = 1'b0;
  logic camera_rstn, cfg_restart, busy, cfg_done, cfg_err;
  logic cfg_restart0, busy0, cfg_done0, cfg_err0;
  logic tr_en;
  logic [23:0] lut_mem [0:255];
  logic [5:0]  m_cnt = '0;
  logic [31:0] exp_q [$];

  int tests_run = 0, fail_cnt = 0;
  int pulses = 0, rise_count = 0, low_len = 0, since_rise = 0, err_lat = -1;
  int tr_rises = 0, idx1_cnt = 0, start0_lows = 0;
  logic prev_start = 1'b1, prev_err = 1'b0, prev_done = 1'b0, prev_tr = 1'b0;

  i2c_reg_seq_if ia();
  i2c_reg_seq_if i0();

  i2c_reg_seq #(.DEV_ADDR(8'h78), .LUT_SIZE(8'd3), .PWRUP_CYC(20'(PWRUP)), .GAP_CYC(8'd4),
                .MS_CYC(16'd5), .TIMEOUT_CYC(8'(TMO))) dut (
    .clock_i2c2(clock_i2c2), .camera_rstn(camera_rstn), .cfg_restart(cfg_restart),
    .i2c(ia), .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err));

  i2c_reg_seq #(.DEV_ADDR(8'h78), .LUT_SIZE(8'd0), .PWRUP_CYC(20'(PWRUP)), .GAP_CYC(8'd4),
                .MS_CYC(16'd5), .TIMEOUT_CYC(8'(TMO))) dut0 (
    .clock_i2c2(clock_i2c2), .camera_rstn(camera_rstn), .cfg_restart(cfg_restart0),
    .i2c(i0), .busy(busy0), .cfg_done(cfg_done0), .cfg_err(cfg_err0));

  always #5 clock_i2c2 = ~clock_i2c2;

  // i2c_com stand-in: counter cleared while start is low, tr_end once 41 cycles have passed with start high.
  always @(posedge clock_i2c2) begin
    if (!ia.start) m_cnt <= '0;
    else if (m_cnt != 6'd63) m_cnt <= m_cnt + 6'd1;
  end
  assign ia.tr_end   = tr_en && (m_cnt >= 6'd41);
  assign ia.lut_data = lut_mem[ia.lut_index];
  assign i0.tr_end   = 1'b0;
  assign i0.lut_data = 24'd0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock_i2c2) begin
    if (!i0.start) start0_lows++;
    if (camera_rstn) begin
      if (prev_start && !ia.start) begin
        pulses++;
        low_len = 1;
        check_output("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_output("i2c_data", ia.i2c_data, exp_q.pop_front());
      end else if (!ia.start) begin
        low_len++;
      end
      if (!prev_start && ia.start) begin
        check_output("start_low_len", 32'(low_len), 32'd2);
        rise_count++;
        since_rise = 0;
      end else begin
        since_rise++;
      end
      if (cfg_err && !prev_err) err_lat = since_rise;
      if (cfg_done && !prev_done) check_output("busy_at_done", 32'(busy), 32'd0);
      if (ia.tr_end && !prev_tr) tr_rises++;
      if (ia.lut_index == 8'd1) idx1_cnt++;
      prev_start = ia.start;
      prev_err   = cfg_err;
      prev_done  = cfg_done;
      prev_tr    = ia.tr_end;
    end
  end

  task automatic apply_stimulus();
    @(negedge clock_i2c2) cfg_restart = 1'b1;
    @(negedge clock_i2c2) cfg_restart = 1'b0;
  endtask

  task automatic push_words(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    exp_q.push_back({8'h78, a});
    exp_q.push_back({8'h78, b});
    exp_q.push_back({8'h78, c});
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && cfg_done !== 1'b1; i++) @(negedge clock_i2c2);
    #1;
    check_output(tag, 32'(cfg_done), 32'd1);
  endtask

  task automatic wait_rises(input int target);
    for (int i = 0; i < 1000 && rise_count < target; i++) @(negedge clock_i2c2);
    check_output("wait_rise", 32'(rise_count >= target), 32'd1);
  endtask

  task automatic release_and_time();
    int n;
    @(negedge clock_i2c2) camera_rstn = 1'b1;
    n = 0;
    do begin
      @(posedge clock_i2c2);
      #1;
      n++;
      if (n == PWRUP) check_output("lut0_done_early", 32'(cfg_done0), 32'd0);
      if (n == PWRUP + 1) begin
        check_output("lut0_done", 32'(cfg_done0), 32'd1);
        check_output("lut0_busy", 32'(busy0), 32'd0);
      end
    end while (ia.start !== 1'b0 && n < 200);
    check_output("first_kick_cycle", 32'(n), 32'(PWRUP + 1));
  endtask

  initial begin
    int p_base, i_base;
    camera_rstn  = 1'b0;
    cfg_restart  = 1'b0;
    cfg_restart0 = 1'b0;
    tr_en        = 1'b1;
    for (int i = 0; i < 256; i++) lut_mem[i] = 24'd0;
    lut_mem[0] = E0;
    lut_mem[1] = E1;
    lut_mem[2] = E2;
    repeat (3) @(negedge clock_i2c2);
    check_output("rst_start", 32'(ia.start), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd1);
    check_output("rst_index", 32'(ia.lut_index), 32'd0);
    check_output("rst_data", ia.i2c_data, 32'd0);
    check_output("rst_done", 32'(cfg_done), 32'd0);
    check_output("rst_err", 32'(cfg_err), 32'd0);
    check_output("rst_fl_read", 32'(ia.fl_read), 32'd0);

    push_words(E0, E1, E2);
    release_and_time();
    wait_done("sweep_done");
    check_output("sweep_pulses", 32'(pulses), 32'd3);
    check_output("sweep_tr_rises", 32'(tr_rises), 32'd3);
    check_output("sweep_err", 32'(cfg_err), 32'd0);
    check_output("sweep_busy", 32'(busy), 32'd0);
    check_output("sweep_entry_period", 32'(idx1_cnt), 32'd49);
    check_output("sweep_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] timeout scenario");
    tr_en  = 1'b0;
    p_base = pulses;
    push_words(E0, E1, E2);
    apply_stimulus();
    wait_done("tmo_done");
    check_output("tmo_err", 32'(cfg_err), 32'd1);
    check_output("tmo_latency", 32'(err_lat), 32'(TMO));
    check_output("tmo_pulses", 32'(pulses - p_base), 32'd3);
    check_output("tmo_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] restart during WAIT scenario");
    tr_en  = 1'b1;
    p_base = pulses;
    push_words(E0, E1, E0);
    exp_q.push_back({8'h78, E1});
    exp_q.push_back({8'h78, E2});
    apply_stimulus();
    check_output("rs_err_clr", 32'(cfg_err), 32'd0);
    check_output("rs_done_clr", 32'(cfg_done), 32'd0);
    check_output("rs_busy", 32'(busy), 32'd1);
    @(posedge clock_i2c2);
    #1;
    check_output("rs_no_pwrup", 32'(ia.start), 32'd0);
    wait_rises(rise_count + 2);
    repeat (20) @(negedge clock_i2c2);
    apply_stimulus();
    wait_done("rs_done");
    check_output("rs_pulses", 32'(pulses - p_base), 32'd5);
    check_output("rs_sb_empty", 32'(exp_q.size()), 32'd0);
    check_output("rs_err", 32'(cfg_err), 32'd0);

    $display("[TB] delay entry scenario");
    lut_mem[1] = EDLY;
    p_base = pulses;
    i_base = idx1_cnt;
`ifdef I2C_SEQ_DELAY_CMD_EN
    exp_q.push_back({8'h78, E0});
    exp_q.push_back({8'h78, E2});
`else
    push_words(E0, EDLY, E2);
`endif
    apply_stimulus();
    wait_done("dly_done");
    check_output("dly_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef I2C_SEQ_DELAY_CMD_EN
    check_output("dly_pulses", 32'(pulses - p_base), 32'd2);
    check_output("dly_entry_cycles", 32'(idx1_cnt - i_base), 32'd26);
`else
    check_output("dly_pulses", 32'(pulses - p_base), 32'd3);
    check_output("dly_entry_cycles", 32'(idx1_cnt - i_base), 32'd49);
`endif

    $display("[TB] async reset scenario");
    lut_mem[1] = E1;
    exp_q.push_back({8'h78, E0});
    apply_stimulus();
    wait_rises(rise_count + 1);
    repeat (15) @(negedge clock_i2c2);
    #2 camera_rstn = 1'b0;
    #1;
    check_output("ar_start", 32'(ia.start), 32'd1);
    check_output("ar_index", 32'(ia.lut_index), 32'd0);
    check_output("ar_busy", 32'(busy), 32'd1);
    check_output("ar_data", ia.i2c_data, 32'd0);
    exp_q.delete();
    push_words(E0, E1, E2);
    repeat (2) @(negedge clock_i2c2);
    release_and_time();
    wait_done("ar_done");
    check_output("ar_sb_empty", 32'(exp_q.size()), 32'd0);
    check_output("lut0_no_start", 32'(start0_lows), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule
